alu_reg: RTL and testbench



---
 rtl/alu_pkg.sv | 31 +++
 rtl/alu_reg_if.sv | 25 ++
 rtl/alu_addsub.sv | 22 ++
 rtl/alu_reg.sv | 87 ++++++++
 tb/tb_alu_reg.sv | 144 ++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared constants and helpers for the registered 32-bit ALU.
// Codes for the optional ops (XOR, NOR, SRA, SLTU) are always defined here.
// Whether they are active depends on ALU_EXT_OPS_EN in alu_reg.
package alu_pkg;

  localparam int XLEN = 32;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_XOR  = 4'd2;
  localparam logic [3:0] ALU_NOR  = 4'd3;
  localparam logic [3:0] ALU_AND  = 4'd4;
  localparam logic [3:0] ALU_OR   = 4'd5;
  localparam logic [3:0] ALU_SLL  = 4'd6;
  localparam logic [3:0] ALU_SRL  = 4'd7;
  localparam logic [3:0] ALU_SLT  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;
  localparam logic [3:0] ALU_SLTU = 4'd10;

  // Signed overflow rule for an add or subtract, using only the sign bits.
  // ADD overflows when the operands share a sign and the sum's sign differs.
  // SUB overflows when the operands differ in sign and the difference's sign
  // differs from op1.
  function automatic logic addSubOverflow(input logic aSign, input logic bSign,
                                          input logic sSign, input logic isSub);
    logic sameSign;
    sameSign = (aSign == bSign);
    return (isSub ? !sameSign : sameSign) && (sSign != aSign);
  endfunction

endpackage

// File: rtl/alu_reg_if.sv
// Operand/control bus into the ALU and the registered result bus out of it.
// The master drives operands and control; the slave (the ALU) drives the results.
interface alu_reg_if;
  import alu_pkg::*;

  logic            in_valid;
  logic [3:0]      ctrl;
  logic [XLEN-1:0] op1;
  logic [XLEN-1:0] op2;
  logic            out_valid;
  logic [XLEN-1:0] result;
  logic            overflow;
  logic            zero;

  modport master (
    output in_valid, ctrl, op1, op2,
    input  out_valid, result, overflow, zero
  );

  modport slave (
    input  in_valid, ctrl, op1, op2,
    output out_valid, result, overflow, zero
  );

endinterface

// File: rtl/alu_addsub.sv
// Combinational 32-bit adder/subtractor shared by ADD and SUB.
// Subtraction is done as op1 + ~op2 + 1, so one carry chain serves both.
module alu_addsub
  import alu_pkg::*;
(
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  input  logic            i_sub,
  output logic [XLEN-1:0] o_sum,
  output logic            o_overflow
);

  logic [XLEN-1:0] w_bEff;

  // Invert B and inject a carry-in of 1 when subtracting.
  always_comb begin
    w_bEff     = i_sub ? ~i_b : i_b;
    o_sum      = i_a + w_bEff + {{(XLEN-1){1'b0}}, i_sub};
    o_overflow = addSubOverflow(i_a[XLEN-1], i_b[XLEN-1], o_sum[XLEN-1], i_sub);
  end

endmodule

// File: rtl/alu_reg.sv
// 32-bit integer ALU with a registered, valid-tagged result (latency 1).
// Define ALU_EXT_OPS_EN to enable XOR, NOR, SRA and SLTU.
// Without that macro, those codes act like any other undefined code:
// the result is 0 and overflow is 0.
module alu_reg
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  alu_reg_if.slave   bus
);

  logic [XLEN-1:0] w_sum;
  logic            w_addSubOvf;
  logic            w_isSub;
  logic [4:0]      w_shamt;
  logic [XLEN-1:0] w_result;
  logic            w_overflow;

  logic            r_valid;
  logic [XLEN-1:0] r_result;
  logic            r_overflow;
  logic            r_zero;

  assign w_isSub = (bus.ctrl == ALU_SUB);
  assign w_shamt = bus.op2[4:0];

  alu_addsub u_addsub (
    .i_a        (bus.op1),
    .i_b        (bus.op2),
    .i_sub      (w_isSub),
    .o_sum      (w_sum),
    .o_overflow (w_addSubOvf)
  );

  // Select the result for the current opcode.
  // Only ADD and SUB can report overflow.
  always_comb begin
    w_result   = '0;
    w_overflow = 1'b0;
    case (bus.ctrl)
      ALU_ADD, ALU_SUB: begin
        w_result   = w_sum;
        w_overflow = w_addSubOvf;
      end
      ALU_AND: w_result = bus.op1 & bus.op2;
      ALU_OR:  w_result = bus.op1 | bus.op2;
      ALU_SLL: w_result = bus.op1 << w_shamt;
      ALU_SRL: w_result = bus.op1 >> w_shamt;
      ALU_SLT: w_result = {{(XLEN-1){1'b0}}, ($signed(bus.op1) < $signed(bus.op2))};
`ifdef ALU_EXT_OPS_EN
      ALU_XOR:  w_result = bus.op1 ^ bus.op2;
      ALU_NOR:  w_result = ~(bus.op1 | bus.op2);
      ALU_SRA:  w_result = $unsigned($signed(bus.op1) >>> w_shamt);
      ALU_SLTU: w_result = {{(XLEN-1){1'b0}}, (bus.op1 < bus.op2)};
`else
      ALU_XOR, ALU_NOR, ALU_SRA, ALU_SLTU: w_result = '0;
`endif
      default: w_result = '0;
    endcase
  end

  // Output register.
  // out_valid follows in_valid every cycle.
  // The data fields load only on a valid op and otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid    <= 1'b0;
      r_result   <= '0;
      r_overflow <= 1'b0;
      r_zero     <= 1'b1;
    end else begin
      r_valid <= bus.in_valid;
      if (bus.in_valid) begin
        r_result   <= w_result;
        r_overflow <= w_overflow;
        r_zero     <= (w_result == '0);
      end
    end
  end

  assign bus.out_valid = r_valid;
  assign bus.result    = r_result;
  assign bus.overflow  = r_overflow;
  assign bus.zero      = r_zero;

endmodule

// File: tb/tb_alu_reg.sv
// Directed testbench for alu_reg.
// Expected values are hand-computed.
// The ALU_EXT_OPS_EN vectors are selected with the same macro as the design.
module tb_alu_reg;
  import alu_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  alu_reg_if bus ();

  alu_reg dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one set of inputs.
  // Inputs are changed just after a falling edge, away from the sampling edge.
  task automatic applyStimulus(input logic v, input logic [3:0] c,
                               input logic [31:0] a, input logic [31:0] b);
    bus.in_valid = v;
    bus.ctrl     = c;
    bus.op1      = a;
    bus.op2      = b;
  endtask

  // Compare all four outputs at once against the expected values.
  task automatic checkOutput(input string tag, input logic expValid,
                             input logic [31:0] expResult, input logic expOvf,
                             input logic expZero);
    logic [34:0] observed;
    logic [34:0] expected;
    observed = {bus.out_valid, bus.result, bus.overflow, bus.zero};
    expected = {expValid, expResult, expOvf, expZero};
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: valid/result/ovf/zero observed %b/%h/%b/%b expected %b/%h/%b/%b",
             tag, observed[34], observed[33:2], observed[1], observed[0],
             expected[34], expected[33:2], expected[1], expected[0]);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    applyStimulus(1'b0, 4'd0, 32'd0, 32'd0);

    // Reset state while rst_n is held low.
    @(negedge clk);
    checkOutput("reset", 1'b0, 32'h0, 1'b0, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back valid ops: each result is checked one cycle after it is issued.
    applyStimulus(1'b1, ALU_ADD, 32'h7FFFFFFF, 32'h7FFFFFFF);
    @(negedge clk); checkOutput("add_ovf", 1'b1, 32'hFFFFFFFE, 1'b1, 1'b0);
    applyStimulus(1'b1, ALU_SUB, 32'd234, 32'd3);
    @(negedge clk); checkOutput("sub", 1'b1, 32'd231, 1'b0, 1'b0);
    applyStimulus(1'b1, ALU_AND, 32'd234, 32'd3);
    @(negedge clk); checkOutput("and", 1'b1, 32'd2, 1'b0, 1'b0);
    applyStimulus(1'b1, ALU_OR, 32'd234, 32'd3);
    @(negedge clk); checkOutput("or", 1'b1, 32'd235, 1'b0, 1'b0);
    applyStimulus(1'b1, ALU_SLL, 32'd234, 32'd3);
    @(negedge clk); checkOutput("sll", 1'b1, 32'd1872, 1'b0, 1'b0);
    applyStimulus(1'b1, ALU_SRL, 32'd234, 32'd3);
    @(negedge clk); checkOutput("srl", 1'b1, 32'd29, 1'b0, 1'b0);
    applyStimulus(1'b1, ALU_SLT, 32'd45, 32'd42);
    @(negedge clk); checkOutput("slt_45_42", 1'b1, 32'd0, 1'b0, 1'b1);
    applyStimulus(1'b1, ALU_SLT, 32'd25, 32'd42);
    @(negedge clk); checkOutput("slt_25_42", 1'b1, 32'd1, 1'b0, 1'b0);
    applyStimulus(1'b1, ALU_SLT, 32'hFFFFFFFF, 32'd42);
    @(negedge clk); checkOutput("slt_m1_42", 1'b1, 32'd1, 1'b0, 1'b0);
    applyStimulus(1'b1, ALU_SLT, 32'hFFFFFFF9, 32'hFFFFFFF0);
    @(negedge clk); checkOutput("slt_m7_m16", 1'b1, 32'd0, 1'b0, 1'b1);
    applyStimulus(1'b1, ALU_SLT, 32'h80000000, 32'h7FFFFFFF);
    @(negedge clk); checkOutput("slt_min_max", 1'b1, 32'd1, 1'b0, 1'b0);
    applyStimulus(1'b1, ALU_SUB, 32'h80000000, 32'd1);
    @(negedge clk); checkOutput("sub_ovf", 1'b1, 32'h7FFFFFFF, 1'b1, 1'b0);
    applyStimulus(1'b1, ALU_ADD, 32'h80000000, 32'h80000000);
    @(negedge clk); checkOutput("add_ovf_zero", 1'b1, 32'h0, 1'b1, 1'b1);
    applyStimulus(1'b1, ALU_ADD, 32'd5, 32'hFFFFFFFB);
    @(negedge clk); checkOutput("add_zero", 1'b1, 32'h0, 1'b0, 1'b1);
    applyStimulus(1'b1, ALU_ADD, 32'hFFFFFFFB, 32'd3);
    @(negedge clk); checkOutput("add_neg", 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0);
    applyStimulus(1'b1, ALU_SLL, 32'd1, 32'hFFFFFFE4);
    @(negedge clk); checkOutput("sll_hi_ignored", 1'b1, 32'd16, 1'b0, 1'b0);
    applyStimulus(1'b1, ALU_SRL, 32'h80000000, 32'd31);
    @(negedge clk); checkOutput("srl_31", 1'b1, 32'd1, 1'b0, 1'b0);
    applyStimulus(1'b1, ALU_SRL, 32'hDEADBEEF, 32'h00000020);
    @(negedge clk); checkOutput("srl_by0", 1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'd15, 32'd234, 32'd3);
    @(negedge clk); checkOutput("undef_15", 1'b1, 32'd0, 1'b0, 1'b1);
    applyStimulus(1'b1, ALU_SUB, 32'd10, 32'd3);
    @(negedge clk); checkOutput("sub_small", 1'b1, 32'd7, 1'b0, 1'b0);

`ifdef ALU_EXT_OPS_EN
    applyStimulus(1'b1, ALU_SRA, 32'hFFFFFFF0, 32'd2);
    @(negedge clk); checkOutput("sra", 1'b1, 32'hFFFFFFFC, 1'b0, 1'b0);
    applyStimulus(1'b1, ALU_SLTU, 32'hFFFFFFFF, 32'd42);
    @(negedge clk); checkOutput("sltu", 1'b1, 32'd0, 1'b0, 1'b1);
    applyStimulus(1'b1, ALU_XOR, 32'd234, 32'd3);
    @(negedge clk); checkOutput("xor", 1'b1, 32'd233, 1'b0, 1'b0);
    applyStimulus(1'b1, ALU_NOR, 32'd234, 32'd3);
    @(negedge clk); checkOutput("nor", 1'b1, 32'hFFFFFF14, 1'b0, 1'b0);
`else
    applyStimulus(1'b1, ALU_SRA, 32'hFFFFFFF0, 32'd2);
    @(negedge clk); checkOutput("code9_undef", 1'b1, 32'd0, 1'b0, 1'b1);
    applyStimulus(1'b1, ALU_SUB, 32'd10, 32'd3);
    @(negedge clk); checkOutput("sub_between", 1'b1, 32'd7, 1'b0, 1'b0);
    applyStimulus(1'b1, ALU_XOR, 32'd234, 32'd3);
    @(negedge clk); checkOutput("code2_undef", 1'b1, 32'd0, 1'b0, 1'b1);
`endif

    // Gap cycles: out_valid drops while the data fields hold their previous values.
    applyStimulus(1'b1, ALU_SUB, 32'h80000000, 32'd1);
    @(negedge clk); checkOutput("pre_gap", 1'b1, 32'h7FFFFFFF, 1'b1, 1'b0);
    applyStimulus(1'b0, ALU_ADD, 32'd0, 32'd0);
    @(negedge clk); checkOutput("gap1_hold", 1'b0, 32'h7FFFFFFF, 1'b1, 1'b0);
    applyStimulus(1'b0, ALU_AND, 32'h12345678, 32'h0);
    @(negedge clk); checkOutput("gap2_hold", 1'b0, 32'h7FFFFFFF, 1'b1, 1'b0);

    // Asynchronous reset arriving between clock edges.
    applyStimulus(1'b1, ALU_ADD, 32'd1, 32'd1);
    @(negedge clk); checkOutput("pre_reset", 1'b1, 32'd2, 1'b0, 1'b0);
    applyStimulus(1'b1, ALU_ADD, 32'd3, 32'd4);
    #2 rst_n = 1'b0;
    #1 checkOutput("async_reset", 1'b0, 32'h0, 1'b0, 1'b1);
    @(negedge clk); checkOutput("reset_drop", 1'b0, 32'h0, 1'b0, 1'b1);
    rst_n = 1'b1;
    @(negedge clk); checkOutput("post_reset", 1'b1, 32'd7, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
